// File: rtl/aftab_pbsu_pkg.sv
// Shared encodings and helpers for the AFTAB pipelined barrel shift unit.
// Holds the selShift mode codes and the mapping of log-shifter levels onto register ranks.
package aftab_pbsu_pkg;

    localparam logic [2:0] SEL_SLL = 3'b000;
    localparam logic [2:0] SEL_SRL = 3'b010;
    localparam logic [2:0] SEL_SRA = 3'b011;
    localparam logic [2:0] SEL_ROL = 3'b100;
    localparam logic [2:0] SEL_ROR = 3'b101;

    // Rank in which log-shifter level k is evaluated.
    function automatic int level_rank(input int k, input int stages, input int shamt_w);
        return (k * stages) / shamt_w;
    endfunction

endpackage

// File: rtl/aftab_pbsu_if.sv
// Request/response bundle of the barrel shift unit.
// slave is the unit side, master is the issuing/consuming side.
interface aftab_pbsu_if #(
    parameter int SIZE    = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
);
    logic               inValid;
    logic               inReady;
    logic [SIZE-1:0]    dataIn;
    logic [SHAMT_W-1:0] shiftAmount;
    logic [2:0]         selShift;
    logic [TAG_W-1:0]   tagIn;
    logic               outValid;
    logic               outReady;
    logic [SIZE-1:0]    dataOut;
    logic [TAG_W-1:0]   tagOut;

    modport slave (
        input  inValid, dataIn, shiftAmount, selShift, tagIn, outReady,
        output inReady, outValid, dataOut, tagOut
    );

    modport master (
        output inValid, dataIn, shiftAmount, selShift, tagIn, outReady,
        input  inReady, outValid, dataOut, tagOut
    );
endinterface

// File: rtl/aftab_pbsu_level.sv
// One level of the log shifter: moves data by 2^K in the direction given by mode when en is set.
// Reserved modes force a zero result regardless of en, so the zero survives every level.
module aftab_pbsu_level
    import aftab_pbsu_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int K    = 0
) (
    input  logic [SIZE-1:0] data,
    input  logic            en,
    input  logic [2:0]      mode,
    output logic [SIZE-1:0] result
);
    localparam int DIST = 1 << K;

    always_comb begin
        result = data;
        case (mode)
            SEL_SLL: if (en) result = data << DIST;
            SEL_SRL: if (en) result = data >> DIST;
            // Earlier arithmetic levels keep the sign bit, so data's MSB is still the operand MSB.
            SEL_SRA: if (en) result = $signed(data) >>> DIST;
            SEL_ROL: if (en) result = (data << DIST) | (data >> (SIZE - DIST));
            SEL_ROR: if (en) result = (data >> DIST) | (data << (SIZE - DIST));
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/aftab_pbsu.sv
// Pipelined barrel shifter: SHAMT_W log-shifter levels spread over STAGES register ranks,
// with a single global advance so the whole pipe moves or holds as one (bubbles included).
module aftab_pbsu
    import aftab_pbsu_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int SHAMT_W = 5,
    parameter int STAGES  = 2,
    parameter int TAG_W   = 5
) (
    input  logic clk,
    input  logic rst,
    aftab_pbsu_if.slave bus
);
    logic [SIZE-1:0]    data_reg  [STAGES];
    logic [SHAMT_W-1:0] shamt_reg [STAGES];
    logic [2:0]         mode_reg  [STAGES];
    logic [TAG_W-1:0]   tag_reg   [STAGES];
    logic               valid_reg [STAGES];

    logic [SIZE-1:0]    rank_data_in  [STAGES];
    logic [SHAMT_W-1:0] rank_shamt_in [STAGES];
    logic [2:0]         rank_mode_in  [STAGES];
    logic [TAG_W-1:0]   rank_tag_in   [STAGES];
    logic               rank_valid_in [STAGES];
    logic [SIZE-1:0]    rank_result   [STAGES];
    logic [SIZE-1:0]    level_out     [SHAMT_W];
    logic               adv;

    assign adv          = ~valid_reg[STAGES-1] | bus.outReady;
    assign bus.inReady  = adv;
    assign bus.outValid = valid_reg[STAGES-1];
    assign bus.dataOut  = data_reg[STAGES-1];
    assign bus.tagOut   = tag_reg[STAGES-1];

    always_comb begin
        rank_data_in[0]  = bus.dataIn;
        rank_shamt_in[0] = bus.shiftAmount;
        rank_mode_in[0]  = bus.selShift;
        rank_tag_in[0]   = bus.tagIn;
        rank_valid_in[0] = bus.inValid;
        for (int r = 1; r < STAGES; r++) begin
            rank_data_in[r]  = data_reg[r-1];
            rank_shamt_in[r] = shamt_reg[r-1];
            rank_mode_in[r]  = mode_reg[r-1];
            rank_tag_in[r]   = tag_reg[r-1];
            rank_valid_in[r] = valid_reg[r-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_level
            localparam int RANK  = level_rank(gi, STAGES, SHAMT_W);
            localparam bit FIRST = (gi == 0) || (level_rank(gi - 1, STAGES, SHAMT_W) != RANK);
            localparam bit LAST  = (gi == SHAMT_W - 1) || (level_rank(gi + 1, STAGES, SHAMT_W) != RANK);
            logic [SIZE-1:0] lvl_in;

            // The first level of a rank reads that rank's registered input; later ones chain.
            if (FIRST) begin : g_first
                assign lvl_in = rank_data_in[RANK];
            end else begin : g_chain
                assign lvl_in = level_out[gi-1];
            end

            aftab_pbsu_level #(.SIZE(SIZE), .K(gi)) u_level (
                .data   (lvl_in),
                .en     (rank_shamt_in[RANK][gi]),
                .mode   (rank_mode_in[RANK]),
                .result (level_out[gi])
            );

            if (LAST) begin : g_last
                assign rank_result[RANK] = level_out[gi];
            end
        end

        for (gi = 0; gi < STAGES; gi++) begin : g_rank
            // Payload only loads with a valid op, so dataOut/tagOut hold across bubbles.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    shamt_reg[gi] <= '0;
                    mode_reg[gi]  <= '0;
                    tag_reg[gi]   <= '0;
                end else if (adv) begin
                    valid_reg[gi] <= rank_valid_in[gi];
                    if (rank_valid_in[gi]) begin
                        data_reg[gi]  <= rank_result[gi];
                        shamt_reg[gi] <= rank_shamt_in[gi];
                        mode_reg[gi]  <= rank_mode_in[gi];
                        tag_reg[gi]   <= rank_tag_in[gi];
                    end
                end
            end
        end
    endgenerate
endmodule
